dom1_skinny_ctrl: RTL and testbench

- Initiator/sequencer for the DOM-1 masked SKINNY-128-384+ round core (dom1_skinny_top).
- Accepts a masked job (two state shares, two key shares, tweak, counter) over valid/ready.
- Streams a fresh 128-bit random mask to the core before every round update and holds the core in reset while idle.
- Cross-checks the core's done timing against its own round count, then returns the two result shares over valid/ready with an error flag.

---
 rtl/dom1_skinny_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_dom1_skinny_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dom1_skinny_ctrl.sv
// Job sequencer for the DOM-1 masked SKINNY-128-384+ round core: feeds the job and a fresh
// 128-bit mask before every round update, checks the core's done timing and returns the shares.
module dom1_skinny_ctrl #(
    parameter int ROUNDS      = 40,
    parameter int CYC_PER_RND = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_s0,
    input  logic [127:0] in_s1,
    input  logic [127:0] in_k0,
    input  logic [127:0] in_k1,
    input  logic [127:0] in_t,
    input  logic [127:0] in_cnt,
    input  logic         rnd_valid,
    output logic         rnd_ready,
    input  logic [127:0] rnd_data,
    output logic         core_rst,
    output logic [127:0] core_sshi0,
    output logic [127:0] core_sshi1,
    output logic [127:0] core_kshi0,
    output logic [127:0] core_kshi1,
    output logic [127:0] core_ti,
    output logic [127:0] core_cnti,
    output logic [127:0] core_ri,
    input  logic [127:0] core_sshr0,
    input  logic [127:0] core_sshr1,
    input  logic         core_done,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_s0,
    output logic [127:0] out_s1,
    output logic         out_err
);
    localparam int PW = (CYC_PER_RND > 1) ? $clog2(CYC_PER_RND) : 1;
    localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [127:0]    buf_q, buf_d;
    logic            full_q, full_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [RW-1:0]   round_q, round_d;
    logic            err_q, err_d;
    logic [127:0]    sshi0_q, sshi0_d, sshi1_q, sshi1_d;
    logic [127:0]    kshi0_q, kshi0_d, kshi1_q, kshi1_d;
    logic [127:0]    ti_q, ti_d, cnti_q, cnti_d;
    logic [127:0]    out_s0_q, out_s0_d, out_s1_q, out_s1_d;
    logic            consume_s;
    logic            rnd_fire_s;
    logic            last_phase_s;

    // Next-state, buffer and job-register logic
    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        full_d       = full_q;
        phase_d      = phase_q;
        round_d      = round_q;
        err_d        = err_q;
        sshi0_d      = sshi0_q;
        sshi1_d      = sshi1_q;
        kshi0_d      = kshi0_q;
        kshi1_d      = kshi1_q;
        ti_d         = ti_q;
        cnti_d       = cnti_q;
        out_s0_d     = out_s0_q;
        out_s1_d     = out_s1_q;
        consume_s    = 1'b0;
        last_phase_s = (phase_q == PW'(CYC_PER_RND - 1));
        rnd_fire_s   = rnd_valid && !full_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && full_q) begin
                    sshi0_d = in_s0;
                    sshi1_d = in_s1;
                    kshi0_d = in_k0;
                    kshi1_d = in_k1;
                    ti_d    = in_t;
                    cnti_d  = in_cnt;
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                consume_s = 1'b1;
                phase_d   = '0;
                round_d   = '0;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                // An empty buffer at the update edge cannot stall the core; it reuses the stale mask.
                err_d = err_q | core_done | (last_phase_s & ~full_q);
                if (last_phase_s) begin
                    consume_s = 1'b1;
                    phase_d   = '0;
                    if (round_q == RW'(ROUNDS - 1)) begin
                        state_d = ST_CHECK;
                    end else begin
                        round_d = round_q + RW'(1);
                        state_d = ST_RUN;
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                    state_d = ST_RUN;
                end
            end
            ST_CHECK: begin
                out_s0_d = core_sshr0;
                out_s1_d = core_sshr1;
                err_d    = err_q | ~core_done;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Refill only when empty, so a word is never consumed in the cycle it arrives.
        if (rnd_fire_s) begin
            full_d = 1'b1;
            buf_d  = rnd_data;
        end else if (consume_s) begin
            full_d = 1'b0;
        end else begin
            full_d = full_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            buf_q    <= 128'd0;
            full_q   <= 1'b0;
            phase_q  <= '0;
            round_q  <= '0;
            err_q    <= 1'b0;
            sshi0_q  <= 128'd0;
            sshi1_q  <= 128'd0;
            kshi0_q  <= 128'd0;
            kshi1_q  <= 128'd0;
            ti_q     <= 128'd0;
            cnti_q   <= 128'd0;
            out_s0_q <= 128'd0;
            out_s1_q <= 128'd0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            full_q   <= full_d;
            phase_q  <= phase_d;
            round_q  <= round_d;
            err_q    <= err_d;
            sshi0_q  <= sshi0_d;
            sshi1_q  <= sshi1_d;
            kshi0_q  <= kshi0_d;
            kshi1_q  <= kshi1_d;
            ti_q     <= ti_d;
            cnti_q   <= cnti_d;
            out_s0_q <= out_s0_d;
            out_s1_q <= out_s1_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE) && full_q;
    assign rnd_ready  = !full_q;
    assign core_rst   = (state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_DONE);
    assign core_sshi0 = sshi0_q;
    assign core_sshi1 = sshi1_q;
    assign core_kshi0 = kshi0_q;
    assign core_kshi1 = kshi1_q;
    assign core_ti    = ti_q;
    assign core_cnti  = cnti_q;
    assign core_ri    = buf_q;
    assign out_valid  = (state_q == ST_DONE);
    assign out_s0     = out_s0_q;
    assign out_s1     = out_s1_q;
    assign out_err    = (state_q == ST_DONE) && err_q;
endmodule

// File: tb/tb_dom1_skinny_ctrl.sv
// Self-checking bench for dom1_skinny_ctrl with a stand-in core that recombines the unmasked
// inputs, so only the controller's share plumbing, mask refresh and timing are exercised.
module tb_dom1_skinny_ctrl;
    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, rnd_valid, rnd_ready, core_rst, core_done;
    logic         out_valid, out_ready, out_err;
    logic [127:0] in_s0, in_s1, in_k0, in_k1, in_t, in_cnt, rnd_data;
    logic [127:0] core_sshi0, core_sshi1, core_kshi0, core_kshi1, core_ti, core_cnti, core_ri;
    logic [127:0] core_sshr0, core_sshr1, out_s0, out_s1, mock_res;

    always #5 clk = ~clk;

    dom1_skinny_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_s0(in_s0), .in_s1(in_s1), .in_k0(in_k0), .in_k1(in_k1), .in_t(in_t), .in_cnt(in_cnt),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_data(rnd_data),
        .core_rst(core_rst), .core_sshi0(core_sshi0), .core_sshi1(core_sshi1),
        .core_kshi0(core_kshi0), .core_kshi1(core_kshi1), .core_ti(core_ti),
        .core_cnti(core_cnti), .core_ri(core_ri), .core_sshr0(core_sshr0),
        .core_sshr1(core_sshr1), .core_done(core_done), .out_valid(out_valid),
        .out_ready(out_ready), .out_s0(out_s0), .out_s1(out_s1), .out_err(out_err)
    );

    function automatic logic [127:0] rot64(input logic [127:0] x);
        return {x[63:0], x[127:64]};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Stand-in core: done after 200 un-reset cycles (mode 0), never (1) or early in round 5 (2).
    int dmode = 0;
    int run_cnt;
    always_ff @(posedge clk) begin
        if (core_rst) run_cnt <= 0;
        else          run_cnt <= run_cnt + 1;
    end
    assign mock_res   = core_sshi0 ^ core_sshi1 ^ core_kshi0 ^ core_kshi1 ^ rot64(core_ti) ^ core_cnti;
    assign core_sshr0 = mock_res ^ core_ri;
    assign core_sshr1 = core_ri;
    assign core_done  = !core_rst && ((dmode == 0 && run_cnt == 200) || (dmode == 2 && run_cnt == 27));

    localparam logic [127:0] P_VEC = 128'ha3994b66ad85a3459f44e92b08f550cb;
    localparam logic [127:0] K_VEC = 128'hab1afac2611012cd8cef952618c3ebe8;
    localparam logic [127:0] T_VEC = 128'hab588a34a47f1ab2dfe9c8293fbea9a5;
    localparam logic [127:0] C_VEC = 128'hdf889548cfc7ea52d296339301797449;

    typedef struct {
        logic [127:0] p, k, tw, cn;
        int pct, hole, dm, hold, pre_empty, exp_err, abort_at;
    } job_t;

    int checks = 0, failures = 0;
    // Reference model of the mask supply: a one-word store, refilled only while empty.
    int           tok = 0;
    logic [127:0] mword = 128'd0;
    bit           uf;
    int           acc;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_rnd(input int pct);
        rnd_valid = ($urandom_range(99) < pct);
        rnd_data  = rand128();
    endtask

    task automatic tick(input bit consume);
        bit fire;
        if (rst) begin
            tok   = 0;
            mword = 128'd0;
        end else begin
            chk("rnd_ready", 128'(rnd_ready), 128'(tok == 0));
            fire = rnd_valid && (tok == 0);
            if (consume) begin
                if (tok == 0) uf = 1'b1;
                else          chk("core_ri", core_ri, mword);
            end
            if (fire) begin
                tok   = 1;
                mword = rnd_data;
                acc++;
            end else if (consume) begin
                tok = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input job_t j);
        logic [127:0] m, n, exp_res, exp_s1;
        bit           accepted;
        int           exp_e;
        m = rand128();
        n = rand128();
        dmode    = j.dm;
        uf       = 1'b0;
        in_s0    = j.p ^ m;
        in_s1    = m;
        in_k0    = j.k ^ n;
        in_k1    = n;
        in_t     = j.tw;
        in_cnt   = j.cn;
        in_valid = 1'b1;
        accepted = 1'b0;
        exp_s1   = 128'd0;
        for (int w = 0; w < 60 && !accepted; w++) begin
            if (w < j.pre_empty) begin
                rnd_valid = 1'b0;
                rnd_data  = rand128();
            end else begin
                drive_rnd(j.pct);
            end
            chk("in_ready_idle", 128'(in_ready), 128'(tok == 1));
            accepted = (tok == 1);
            tick(1'b0);
        end
        in_valid = 1'b0;
        if (!accepted) begin
            chk("accept_timeout", 128'(0), 128'(1));
            return;
        end
        acc     = 0;
        exp_res = j.p ^ j.k ^ rot64(j.tw) ^ j.cn;
        for (int k = 1; k <= 202; k++) begin
            if (k == j.abort_at) begin
                rst = 1'b1;
                tick(1'b0);
                rst = 1'b0;
                chk("abort_out_valid", 128'(out_valid), 128'(0));
                chk("abort_core_rst", 128'(core_rst), 128'(1));
                chk("abort_rnd_ready", 128'(rnd_ready), 128'(1));
                chk("abort_in_ready", 128'(in_ready), 128'(0));
                return;
            end
            if (j.hole >= 0 && k >= 2 + 5 * j.hole && k <= 6 + 5 * j.hole) begin
                rnd_valid = 1'b0;
                rnd_data  = rand128();
            end else begin
                drive_rnd(j.pct);
            end
            if (k == 1) begin
                chk("load_core_rst", 128'(core_rst), 128'(1));
                chk("load_state", core_sshi0 ^ core_sshi1, j.p);
                chk("load_key", core_kshi0 ^ core_kshi1, j.k);
                chk("load_tweak", core_ti, j.tw);
                chk("load_cnt", core_cnti, j.cn);
            end
            if (k == 2) chk("run_core_rst", 128'(core_rst), 128'(0));
            if (k == 202) begin
                chk("check_out_valid", 128'(out_valid), 128'(0));
                chk("check_core_rst", 128'(core_rst), 128'(0));
                exp_s1 = mword;
            end
            tick(k == 1 || (k >= 2 && (k - 2) % 5 == 4));
        end
        exp_e = (j.exp_err >= 0) ? j.exp_err : int'(uf);
        chk("done_out_valid", 128'(out_valid), 128'(1));
        chk("done_out_err", 128'(out_err), 128'(exp_e));
        chk("done_result", out_s0 ^ out_s1, exp_res);
        chk("done_core_rst", 128'(core_rst), 128'(1));
        if (j.pct == 100 && j.hole < 0) chk("rnd_accepts", 128'(acc), 128'(41));
        for (int h = 0; h < j.hold; h++) begin
            drive_rnd(j.pct);
            in_valid = 1'b1;
            chk("hold_in_ready", 128'(in_ready), 128'(0));
            chk("hold_out_valid", 128'(out_valid), 128'(1));
            chk("hold_out_s0", out_s0, exp_res ^ exp_s1);
            chk("hold_out_s1", out_s1, exp_s1);
            tick(1'b0);
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        drive_rnd(j.pct);
        chk("release_in_ready", 128'(in_ready), 128'(0));
        tick(1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("idle_out_valid", 128'(out_valid), 128'(0));
        chk("idle_out_err", 128'(out_err), 128'(0));
    endtask

    job_t rows[8];
    job_t rj;

    initial begin
        rows[0] = '{P_VEC, K_VEC, T_VEC, C_VEC, 100, -1, 0, 0, 4, 0, 0};
        rows[1] = '{P_VEC, K_VEC, T_VEC, C_VEC, 100, 10, 0, 0, 0, 1, 0};
        rows[2] = '{P_VEC, K_VEC, T_VEC, C_VEC, 100, -1, 0, 0, 0, 0, 0};
        rows[3] = '{rand128(), rand128(), rand128(), rand128(), 100, -1, 1, 0, 0, 1, 0};
        rows[4] = '{rand128(), rand128(), rand128(), rand128(), 100, -1, 2, 0, 0, 1, 0};
        rows[5] = '{rand128(), rand128(), rand128(), rand128(), 100, -1, 0, 20, 0, 0, 0};
        rows[6] = '{rand128(), rand128(), rand128(), rand128(), 100, -1, 0, 0, 0, 0, 100};
        rows[7] = '{P_VEC, K_VEC, T_VEC, C_VEC, 100, -1, 0, 2, 3, 0, 0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rnd_valid = 1'b0;
        rnd_data  = 128'd0;
        in_s0 = 128'd0; in_s1 = 128'd0; in_k0 = 128'd0; in_k1 = 128'd0;
        in_t  = 128'd0; in_cnt = 128'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_err", 128'(out_err), 128'(0));
        chk("rst_rnd_ready", 128'(rnd_ready), 128'(1));
        chk("rst_core_rst", 128'(core_rst), 128'(1));
        chk("rst_out_s0", out_s0, 128'd0);
        chk("rst_out_s1", out_s1, 128'd0);
        chk("rst_core_sshi0", core_sshi0, 128'd0);
        chk("rst_core_ri", core_ri, 128'd0);
        rst = 1'b0;

        for (int r = 0; r < 8; r++) run_job(rows[r]);

        for (int r = 0; r < 6; r++) begin
            rj = '{rand128(), rand128(), rand128(), rand128(),
                   int'($urandom_range(100, 55)), -1, 0, int'($urandom_range(3, 0)), 0, -1, 0};
            run_job(rj);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
